// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and the matching receiver.
// Holds the FSM state type, the counter-width helper and the default word width.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  // Bits needed to count 0 .. width-1.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register feeding the serial line.
// The bit at the head of the register is the one currently on the wire.
module serial_shift_reg
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] par_in,
  output logic             ser_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = par_in;
    end else if (shift) begin
      data_d = MSB_FIRST ? {data_q[WIDTH-2:0], 1'b0}
                         : {1'b0, data_q[WIDTH-1:1]};
    end
  end

  // NOTE: the data register is cleared on reset too, so a discarded word can
  // never reappear on the line if the valid qualifier were ever mis-timed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign ser_out = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter with valid/ready input and first/last
// framing strobes. One bit per clock; back-to-back words have no idle gap.
module serial_tx
  import serial_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_data,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;

  logic at_last;
  logic accept;
  logic load;
  logic shift;
  logic ser_bit;

  // Ready in the last-bit cycle lets the next word follow with no gap.
  assign at_last   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign din_ready = reset && ((state_q == IDLE) || at_last);
  assign accept    = din_valid && din_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    valid_d = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          load    = 1'b1;
          valid_d = 1'b1;
          first_d = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (accept) begin
            load    = 1'b1;
            valid_d = 1'b1;
            first_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          shift   = 1'b1;
          valid_d = 1'b1;
          last_d  = (cnt_d == LAST_CNT);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == SHIFT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // updates from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  serial_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .shift  (shift),
    .par_in (din_data),
    .ser_out(ser_bit)
  );

  // Both mux inputs are flops, so nothing from din_* reaches sout in-cycle.
  assign sout       = valid_q ? ser_bit : IDLE_LEVEL;
  assign sout_valid = valid_q;
  assign sout_first = first_q;
  assign sout_last  = last_q;
  assign busy       = busy_q;

  a_last_is_valid : assert property (@(posedge clk) disable iff (!reset)
    sout_last |-> sout_valid);
  a_cnt_in_range : assert property (@(posedge clk) disable iff (!reset)
    cnt_q <= LAST_CNT);
  a_first_not_last : assert property (@(posedge clk) disable iff (!reset)
    !(sout_first && sout_last));

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-in, serial-out transmitter. It is the driving end of the single-bit serial data line that our D flip-flop and shift-register receivers sample. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock. Framing strobes mark the first and last bit so a downstream deserializer can re-align.

Parameters:
WIDTH, 8, word width in bits; legal range >= 2
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first
IDLE_LEVEL, 0, value driven on sout when no bit is being sent

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk)
din_data  input  WIDTH  parallel word to transmit
din_valid  input  1  din_data is valid
din_ready  output  1  transmitter can accept a word this cycle
sout  output  1  serial data bit
sout_valid  output  1  sout carries a data bit this cycle
sout_first  output  1  sout carries the first bit of a word
sout_last  output  1  sout carries the last bit of a word
busy  output  1  a word is being shifted out

Behaviour:
- Reset (reset==0 at a rising edge):
  - Next cycle: sout=IDLE_LEVEL; sout_valid, sout_first, sout_last and busy all 0; state=IDLE; bit counter=0; shift register cleared.
  - din_ready is forced to 0 while reset is low.
- FSM states: IDLE and SHIFT.
- IDLE:
  - din_ready=1.
  - If din_valid && din_ready at edge k, capture din_data and go to SHIFT with counter=0.
  - Otherwise hold; sout=IDLE_LEVEL.
- SHIFT:
  - All serial outputs are registered.
  - The cycle after edge k carries bit 0 of the transmit order, with sout_valid=1 and sout_first=1.
  - Each following edge advances the counter by 1.
  - The cycle with counter==WIDTH-1 carries the final bit with sout_last=1.
  - busy=1 for exactly WIDTH cycles per word.
- Bit order: MSB_FIRST=1 sends din_data[WIDTH-1] down to [0]; MSB_FIRST=0 sends [0] up to [WIDTH-1].
- din_ready is combinational: din_ready = reset && (state==IDLE || (state==SHIFT && counter==WIDTH-1)).
- Back-to-back transfers:
  - A handshake during the last-bit cycle loads the next word. Its first bit follows immediately with no idle gap; sout_first is asserted in the cycle right after sout_last.
  - Sustained throughput is one word per WIDTH cycles.
- End of word with no handshake during the last-bit cycle: go to IDLE. The next cycle has sout=IDLE_LEVEL and sout_valid=0.
- Input isolation: din_data and din_valid are ignored whenever din_ready=0. Changing din_data mid-word does not affect bits already captured.
- Reset mid-word: the word in flight is discarded. Outputs return to reset values the next cycle, and no partial sout_last is emitted.
- Bit counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1 and wraps to 0 on reload.
- No combinational path exists from din_* to sout*.

Decomposition:
- Shared package serial_pkg holds:
  - state enum tx_state_t {IDLE, SHIFT};
  - function cnt_w(WIDTH) returning $clog2(WIDTH);
  - localparam DEFAULT_WIDTH=8.
- The package is reused by the matching serial receiver.
- One natural sub-module: serial_shift_reg.
  - Parameters: WIDTH and MSB_FIRST.
  - Ports: load, shift, parallel in, serial out bit.
  - serial_tx keeps the FSM, counter, handshake and framing strobes.

Test Plan:
- Reset check: hold reset=0 for 2 cycles with din_valid=1 -> din_ready=0, sout=0, sout_valid=0, busy=0. Release reset -> din_ready=1 in the next cycle.
- Single word, MSB_FIRST=1: send 8'hA5 -> sout=1,0,1,0,0,1,0,1 over 8 consecutive cycles with sout_valid=1. sout_first is asserted on the 1st bit and sout_last on the 8th. The 9th cycle returns to idle with sout=0.
- Back-to-back: send 8'hA5 then 8'h3C, with din_valid held high -> 16 contiguous valid bits 10100101 00111100. sout_first is asserted in cycle 9 and din_ready pulses only in cycles 8 and 16.
- Busy-time isolation: send 8'hFF, then change din_data to 8'h00 and hold din_valid=1 mid-word -> all 8 bits are 1 and no second acceptance occurs before the last-bit cycle.
- Reset mid-word: send 8'hF0 and drive reset=0 after 3 bits -> the next cycle has sout_valid=0 and no sout_last. A subsequent 8'h81 transmits 1,0,0,0,0,0,0,1 cleanly.
- LSB order: MSB_FIRST=0, WIDTH=4, send 4'b0001 -> sout=1,0,0,0 with sout_first on bit 1 and sout_last on bit 4.
